// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, host opcodes and the 1149.1
// transition function shared by the host and the target TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    tl_reset,
    runtest_idle,
    select_dr,
    capture_dr,
    shift_dr,
    exit1_dr,
    pause_dr,
    exit2_dr,
    update_dr,
    select_ir,
    capture_ir,
    shift_ir,
    exit1_ir,
    pause_ir,
    exit2_ir,
    update_ir
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET,
    OP_IDLE,
    OP_SHIFT_IR,
    OP_SHIFT_DR
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_RSP
  } host_fsm_t;

  function automatic tap_state_t next_tap_state(
    input tap_state_t s,
    input logic       tms
  );
    tap_state_t n;
    n = tl_reset;
    case (s)
      tl_reset:     n = tms ? tl_reset  : runtest_idle;
      runtest_idle: n = tms ? select_dr : runtest_idle;
      select_dr:    n = tms ? select_ir : capture_dr;
      capture_dr:   n = tms ? exit1_dr  : shift_dr;
      shift_dr:     n = tms ? exit1_dr  : shift_dr;
      exit1_dr:     n = tms ? update_dr : pause_dr;
      pause_dr:     n = tms ? exit2_dr  : pause_dr;
      exit2_dr:     n = tms ? update_dr : shift_dr;
      update_dr:    n = tms ? select_dr : runtest_idle;
      select_ir:    n = tms ? tl_reset  : capture_ir;
      capture_ir:   n = tms ? exit1_ir  : shift_ir;
      shift_ir:     n = tms ? exit1_ir  : shift_ir;
      exit1_ir:     n = tms ? update_ir : pause_ir;
      pause_ir:     n = tms ? exit2_ir  : pause_ir;
      exit2_ir:     n = tms ? update_ir : shift_ir;
      update_ir:    n = tms ? select_dr : runtest_idle;
      default:      n = tl_reset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider; low phase then high phase of CLK_DIV
// clks each while run is high, with strobes on the toggle cycles.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic trst,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = run && (cnt == TOP);
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_host.sv
// jtag_host: command-driven JTAG sequencer mirroring the target TAP.
// Define JTAG_HOST_STATE_OUT_EN to expose the mirror as tap_state.
module jtag_host
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  localparam int LW = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
`ifdef JTAG_HOST_STATE_OUT_EN
  ,
  output logic [3:0]         tap_state
`endif
);

  localparam logic [LW:0] RST_TCKS = (LW+1)'(6);
  localparam logic [LW:0] RST_ONES = (LW+1)'(5);

  host_fsm_t          state, state_d;
  cmd_op_t            op_q, op_s;
  logic [LW-1:0]      len_q, len_s;
  logic [MAX_LEN-1:0] data_q;
  logic [LW:0]        cnt, cnt_s;
  tap_state_t         mirror;
  logic run, fall_stb, rise_stb;
  logic accept, in_shift, last, cnt_inc;
  logic tms_c, tdi_c;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk      (clk),
    .trst     (trst),
    .run      (run),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) state <= S_WAIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    run       = 1'b0;
    unique case (state)
      S_WAIT: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_RUN;
      end
      S_RUN: begin
        run = 1'b1;
        if (fall_stb && last)
          state_d = op_q[1] ? S_RSP : S_WAIT;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // At acceptance the first TMS comes straight from the command inputs.
  always_comb begin
    accept   = cmd_valid && (state == S_WAIT);
    op_s     = accept ? cmd_op_t'(cmd_op) : op_q;
    len_s    = accept ? cmd_len : len_q;
    cnt_s    = accept ? '0 : cnt;
    in_shift = (mirror == shift_dr) || (mirror == shift_ir);
    tdi_c    = in_shift ? data_q[cnt_s[LW-1:0]] : 1'b0;
    tms_c    = 1'b0;
    case (op_s)
      OP_RESET: tms_c = cnt_s < RST_ONES;
      OP_IDLE:  tms_c = 1'b0;
      default: begin
        case (mirror)
          runtest_idle, exit1_dr, exit1_ir,
          pause_dr, pause_ir, exit2_dr, exit2_ir:
            tms_c = 1'b1;
          select_dr:
            tms_c = (op_s == OP_SHIFT_IR);
          shift_dr, shift_ir:
            tms_c = (cnt_s == {1'b0, len_s});
          default:
            tms_c = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    last    = 1'b0;
    cnt_inc = 1'b0;
    case (op_q)
      OP_RESET: begin
        last    = (cnt == RST_TCKS);
        cnt_inc = 1'b1;
      end
      OP_IDLE: begin
        last    = (cnt == {1'b0, len_q} + 1'b1);
        cnt_inc = (mirror != tl_reset);
      end
      default: begin
        last    = (mirror == runtest_idle) && (cnt != '0);
        cnt_inc = in_shift;
      end
    endcase
  end

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      tms      <= 1'b1;
      tdi      <= 1'b0;
      op_q     <= OP_RESET;
      len_q    <= '0;
      data_q   <= '0;
      cnt      <= '0;
      mirror   <= tl_reset;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op_t'(cmd_op);
        len_q    <= cmd_len;
        data_q   <= cmd_data;
        cnt      <= '0;
        rsp_data <= '0;
      end
      if (accept || (fall_stb && !last)) begin
        tms <= tms_c;
        tdi <= tdi_c;
      end else if (fall_stb) begin
        tdi <= 1'b0;
      end
      if (rise_stb) begin
        mirror <= next_tap_state(mirror, tms);
        if (cnt_inc) cnt <= cnt + 1'b1;
        if (in_shift) rsp_data[cnt[LW-1:0]] <= tdo;
      end
    end
  end

`ifdef JTAG_HOST_STATE_OUT_EN
  assign tap_state = mirror;
`endif

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed bench driving jtag_host into a behavioural
// TAP target (4-bit IR capturing 4'b0001, BYPASS DR).
module tb_jtag_host;
  import jtag_pkg::*;

  localparam int D  = 2;
  localparam int ML = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          trst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [ML-1:0] rsp_data;
  logic          tck, tms, tdi;
  logic          tdo;
`ifdef JTAG_HOST_STATE_OUT_EN
  logic [3:0]    tap_state;
`endif

  int checks = 0;
  int failures = 0;
  int base = 0;
  logic          tms_log[$];
  logic          tdi_log[$];
  logic [ML-1:0] exp_q[$];

  always #5 clk = ~clk;

  jtag_host #(.CLK_DIV(D), .MAX_LEN(ML)) dut (
    .clk       (clk),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
`ifdef JTAG_HOST_STATE_OUT_EN
    ,
    .tap_state (tap_state)
`endif
  );

  // Behavioural target TAP
  tap_state_t tgt;
  logic [3:0] ir_sr;
  logic       bp;

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tgt   <= tl_reset;
      ir_sr <= 4'd0;
      bp    <= 1'b0;
    end else begin
      if (tgt == capture_ir) ir_sr <= 4'b0001;
      if (tgt == shift_ir)   ir_sr <= {tdi, ir_sr[3:1]};
      if (tgt == capture_dr) bp <= 1'b0;
      if (tgt == shift_dr)   bp <= tdi;
      case (tgt)
        tl_reset:     tgt <= tms ? tl_reset  : runtest_idle;
        runtest_idle: tgt <= tms ? select_dr : runtest_idle;
        select_dr:    tgt <= tms ? select_ir : capture_dr;
        capture_dr:   tgt <= tms ? exit1_dr  : shift_dr;
        shift_dr:     tgt <= tms ? exit1_dr  : shift_dr;
        exit1_dr:     tgt <= tms ? update_dr : pause_dr;
        pause_dr:     tgt <= tms ? exit2_dr  : pause_dr;
        exit2_dr:     tgt <= tms ? update_dr : shift_dr;
        update_dr:    tgt <= tms ? select_dr : runtest_idle;
        select_ir:    tgt <= tms ? tl_reset  : capture_ir;
        capture_ir:   tgt <= tms ? exit1_ir  : shift_ir;
        shift_ir:     tgt <= tms ? exit1_ir  : shift_ir;
        exit1_ir:     tgt <= tms ? update_ir : pause_ir;
        pause_ir:     tgt <= tms ? exit2_ir  : pause_ir;
        exit2_ir:     tgt <= tms ? update_ir : shift_ir;
        default:      tgt <= tms ? select_dr : runtest_idle;
      endcase
    end
  end

  always @(negedge tck or negedge trst) begin
    if (!trst)                tdo <= 1'b0;
    else if (tgt == shift_ir) tdo <= ir_sr[0];
    else if (tgt == shift_dr) tdo <= bp;
    else                      tdo <= 1'b0;
  end

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tck"}, 64'(tck), 64'(0));
    chk({tag, "_tms"}, 64'(tms), 64'(1));
    chk({tag, "_tdi"}, 64'(tdi), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
  endtask

  task automatic send(input cmd_op_t op, input int len,
                      input logic [ML-1:0] data);
    @(negedge clk);
    chk("send_ready", 64'(cmd_ready), 64'(1));
    cmd_op    = op;
    cmd_len   = LW'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    base      = tms_log.size();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input bit shift,
                          input int t);
    int cyc = 0;
    bit got = 0;
    bit bad = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (shift) got = rsp_valid;
      else begin
        got = cmd_ready;
        if (rsp_valid) bad = 1;
      end
    end
    chk({tag, "_cycles"}, 64'(cyc), 64'(2*D*t + 1));
    if (!shift) chk({tag, "_no_rsp"}, 64'(bad), 64'(0));
  endtask

  task automatic chk_seq(input string tag, input int n,
                         input logic [63:0] etms,
                         input logic [63:0] etdi);
    logic [63:0] t = '0;
    logic [63:0] d = '0;
    int got = tms_log.size() - base;
    chk({tag, "_tcks"}, 64'(got), 64'(n));
    for (int k = 0; k < got && k < 64; k++) begin
      t[k] = tms_log[base + k];
      d[k] = tdi_log[base + k];
    end
    chk({tag, "_tms"}, t, etms);
    chk({tag, "_tdi"}, d, etdi);
  endtask

  task automatic take_rsp(input string tag);
    logic [ML-1:0] e = 'x;
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, 64'(rsp_data), 64'(e));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    trst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    trst = 1'b1;

    // SHIFT_DR len=0 straight out of Test-Logic-Reset
    exp_q.push_back(32'h0);
    send(OP_SHIFT_DR, 0, 32'h1);
    wait_end("dr0", 1'b1, 7);
    chk_seq("dr0", 7, 64'h32, 64'h10);
    take_rsp("dr0_data");
    chk("dr0_tgt_idle", 64'(tgt), 64'(runtest_idle));

    @(negedge clk) trst = 1'b0;
    @(negedge clk) trst = 1'b1;

    send(OP_RESET, 0, 32'h0);
    wait_end("rst", 1'b0, 6);
    chk_seq("rst", 6, 64'h1F, 64'h0);
    chk("rst_tgt_idle", 64'(tgt), 64'(runtest_idle));
`ifdef JTAG_HOST_STATE_OUT_EN
    chk("rst_mirror", 64'(tap_state), 64'(runtest_idle));
`endif

    send(OP_IDLE, 2, 32'h0);
    wait_end("idle", 1'b0, 3);
    chk_seq("idle", 3, 64'h0, 64'h0);

    // SHIFT_IR, then hold the response for 10 clks
    exp_q.push_back(32'h1);
    send(OP_SHIFT_IR, 3, 32'hA);
    wait_end("ir", 1'b1, 10);
    chk_seq("ir", 10, 64'h183, 64'hA0);
    cmd_op    = OP_IDLE;
    cmd_len   = 5'd4;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_data", 64'(rsp_data), 64'(exp_q[0]));
      chk("hold_ready", 64'(cmd_ready), 64'(0));
    end
    cmd_valid = 1'b0;
    chk("hold_no_tck", 64'(tms_log.size() - base), 64'(10));
    take_rsp("ir_data");
    chk("after_hs_ready", 64'(cmd_ready), 64'(1));

    exp_q.push_back(32'hBD5B7DDE);
    send(OP_SHIFT_DR, 31, 32'hDEADBEEF);
    wait_end("dr32", 1'b1, 37);
    chk_seq("dr32", 37, 64'hC_0000_0001, 64'(32'hDEADBEEF) << 3);
    take_rsp("dr32_data");

    // trst while bit 5 of a 16-bit DR shift is in progress
    send(OP_SHIFT_DR, 15, 32'hA5C3);
    n = 0;
    while ((tms_log.size() - base) < 9 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", 64'((tms_log.size() - base) >= 9), 64'(1));
    trst = 1'b0;
    #1 chk_reset("abort");
    repeat (3) @(negedge clk);
    trst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || tck) seen = 1;
    end
    chk("abort_quiet", 64'(seen), 64'(0));

    send(OP_RESET, 0, 32'h0);
    wait_end("rst2", 1'b0, 6);
    chk_seq("rst2", 6, 64'h1F, 64'h0);
    chk("rst2_tgt_idle", 64'(tgt), 64'(runtest_idle));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
# jtag_host

JTAG host sequencer: the probe-side end of the TAP link. It turns a command stream (reset, idle, shift IR, shift DR) into TCK/TMS/TDI waveforms and returns the captured TDO bits. It sits between an on-chip debug command source and the external/internal TAP pins, driving any IEEE 1149.1 target such as the team's TAP controller.

## Interface
- CLK_DIV, 2, TCK half-period in clk cycles (≥1)
- MAX_LEN, 32, max shift length in bits; LW = $clog2(MAX_LEN)
- clk  in  1  system clock
- trst  in  1  reset trst, asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_op  in  2  0=RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR
- cmd_len  in  LW  bit count minus one (N = cmd_len+1)
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid / rsp_ready  out/in  1  response handshake (shift ops only)
- rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit, bits ≥N zero
- tck, tms, tdi  out  1  JTAG drive
- tdo  in  1  JTAG return

## Operation
- Host mirrors target TAP state (4-bit encoding, tl_reset=0 … update_ir=15) and advances it on every TCK rising edge using the standard transition rules.
- Every command except RESET starts and ends in Run-Test/Idle. If the mirror is Test-Logic-Reset at acceptance, one TMS=0 TCK is prepended.
- RESET: TMS 1,1,1,1,1,0 (6 TCK) → Idle. No response.
- IDLE: N TCKs with TMS=0. No response.
- SHIFT_IR: TMS 1,1,0,0, then N shift TCKs (TMS=0, last=1), then 1,0 → Idle. 6+N TCKs.
- SHIFT_DR: TMS 1,0,0, then N shift TCKs (last TMS=1), then 1,0. 5+N TCKs.
- TDI = cmd_data[i] during shift TCK i, else 0. TDO sampled on each shift TCK rising edge into rsp_data[i].
- FSM: IDLE_WAIT → RUN (per-TCK TMS sequencer, bit counter) → RSP (shift ops) → IDLE_WAIT.
- cmd_ready=1 only in IDLE_WAIT. Commands are not accepted while a response is pending.

## Timing
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, mirror=tl_reset. trst takes effect immediately, including mid-command. The in-flight command and any pending response are discarded.
- Each TCK: low phase of CLK_DIV clks, then high phase of CLK_DIV clks. tms/tdi update on the clk edge that drives tck low.
- tdo is registered on the clk edge that drives tck high.
- Acceptance at cycle 0: first low phase starts at cycle 1. A command of T TCKs ends at cycle 2·CLK_DIV·T. rsp_valid rises the next cycle and is held until rsp_ready; rsp_data is stable while rsp_valid=1.
- Non-shift commands return to cmd_ready=1 the cycle after the last high phase.
- Between commands: tck=0, tms holds last value, tdi=0.
- cmd_len ≥ MAX_LEN is impossible by width. A command issued while cmd_ready=0 is ignored.

## Configuration
- JTAG_HOST_STATE_OUT_EN defined: adds output port tap_state [3:0] exposing the mirrored TAP state, registered and updated on each TCK rising edge.
- Undefined: port absent. The mirror remains internal, and functional behaviour is identical.

## Structure
- Shared package jtag_pkg holds:
  - tap_state_t enum (16 states, encoding above)
  - cmd_op_t enum
  - next_tap_state(state, tms) function, shared with the target-side TAP controller
- Sub-module jtag_tck_gen: CLK_DIV counter producing tck and one-cycle fall_stb/rise_stb strobes, with a run enable. The rest of jtag_host is the command FSM and shift registers.

## Test plan
Bench uses CLK_DIV=2, MAX_LEN=32, with a behavioural TAP target (IR=4 bits, capture 4'b0001, BYPASS DR) except where noted.
- RESET after trst release → TMS 1,1,1,1,1,0 on 6 TCKs, done in 24 clks, no rsp_valid, mirror=runtest_idle.
- SHIFT_IR len=3, data 4'b1010 from Idle → TMS 1,1,0,0,0,0,0,1,1,0; TDI 0,1,0,1 on shift TCKs; rsp_data=32'h1.
- SHIFT_DR len=31, data 32'hDEADBEEF through BYPASS → rsp_data=32'hBD5B7DDE; 37 TCKs.
- SHIFT_DR len=0 directly after trst (mirror tl_reset) → prepended TMS=0, total 7 TCKs, ends in Idle.
- rsp_ready held low 10 clks → rsp_valid and rsp_data held, cmd_ready=0; next command accepted the cycle after the handshake.
- trst asserted mid-shift (bit 5 of 16) → all outputs at reset values that cycle, no rsp_valid; subsequent RESET behaves normally.
